// File: rtl/sprite_mover.sv
`default_nettype none
// =============================================================================
// Module   : sprite_mover
// Brief    : Sprite position/clamp engine with raster ROM addressing and a
//            sprite_on flag delay-matched to the ROM read latency.
//            Optional macro SPRITE_SCALE2X_EN displays the sprite at 2x size.
// Revision : 1.0 - initial release
// =============================================================================
module sprite_mover #(
  parameter int SPRITE_W    = 15,
  parameter int SPRITE_H    = 15,
  parameter int ADDR_W      = 10,
  parameter int START_X     = 400,
  parameter int START_Y     = 300,
  parameter int BOX_X_MIN   = 217,
  parameter int BOX_X_MAX   = 402,
  parameter int BOX_Y_MIN   = 200,
  parameter int BOX_Y_MAX   = 375,
  parameter int STEP        = 5,
  parameter int ROM_LATENCY = 1
) (
  input  logic              Pclk,
  input  logic              rst,
  input  logic [9:0]        xx,
  input  logic [9:0]        yy,
  input  logic              aactive,
  input  logic              frame_start,
  input  logic [2:0]        dir,
  input  logic              load_en,
  input  logic [9:0]        load_x,
  input  logic [9:0]        load_y,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              sprite_on,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic [3:0]        at_edge
);

`ifdef SPRITE_SCALE2X_EN
  localparam int c_SHIFT = 1;
`else
  localparam int c_SHIFT = 0;
`endif
  localparam int c_HIT_W = SPRITE_W << c_SHIFT;
  localparam int c_HIT_H = SPRITE_H << c_SHIFT;

  localparam logic [10:0] c_XMIN = 11'(BOX_X_MIN);
  localparam logic [10:0] c_XMAX = 11'(BOX_X_MAX);
  localparam logic [10:0] c_YMIN = 11'(BOX_Y_MIN);
  localparam logic [10:0] c_YMAX = 11'(BOX_Y_MAX);
  localparam logic [10:0] c_STEP = 11'(STEP);

  localparam int c_RST_X_I = (START_X < BOX_X_MIN) ? BOX_X_MIN :
                             ((START_X > BOX_X_MAX) ? BOX_X_MAX : START_X);
  localparam int c_RST_Y_I = (START_Y < BOX_Y_MIN) ? BOX_Y_MIN :
                             ((START_Y > BOX_Y_MAX) ? BOX_Y_MAX : START_Y);
  localparam logic [9:0] c_RST_X = 10'(c_RST_X_I);
  localparam logic [9:0] c_RST_Y = 10'(c_RST_Y_I);

  // All position arithmetic is done in 11 bits so nothing wraps at 0 or 1023.
  function automatic logic [9:0] clamp10(input logic [9:0] v,
                                         input logic [10:0] lo,
                                         input logic [10:0] hi);
    if ({1'b0, v} < lo)      return lo[9:0];
    else if ({1'b0, v} > hi) return hi[9:0];
    else                     return v;
  endfunction

  function automatic logic [9:0] step_dec(input logic [9:0] p, input logic [10:0] lo);
    return ({1'b0, p} < lo + c_STEP) ? lo[9:0] : 10'({1'b0, p} - c_STEP);
  endfunction

  function automatic logic [9:0] step_inc(input logic [9:0] p, input logic [10:0] hi);
    return ({1'b0, p} + c_STEP > hi) ? hi[9:0] : 10'({1'b0, p} + c_STEP);
  endfunction

  logic [9:0]         r_pos_x, r_pos_y;
  logic [9:0]         w_nx, w_ny;
  logic               w_up, w_dn, w_lf, w_rt;
  logic [3:0]         r_at_edge;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [ROM_LATENCY:0] r_on_pipe;

  always_comb begin
    w_up = 1'b0;
    w_dn = 1'b0;
    w_lf = 1'b0;
    w_rt = 1'b0;
    case (dir)
      3'b000: w_up = 1'b1;
      3'b001: w_dn = 1'b1;
      3'b010: w_lf = 1'b1;
      3'b011: w_rt = 1'b1;
      3'b100: begin w_up = 1'b1; w_lf = 1'b1; end
      3'b101: begin w_up = 1'b1; w_rt = 1'b1; end
      3'b110: begin w_dn = 1'b1; w_lf = 1'b1; end
      default: begin w_dn = 1'b1; w_rt = 1'b1; end
    endcase
  end

  // Teleport wins over the frame move issued in the same cycle.
  always_comb begin
    w_nx = r_pos_x;
    w_ny = r_pos_y;
    if (load_en) begin
      w_nx = clamp10(load_x, c_XMIN, c_XMAX);
      w_ny = clamp10(load_y, c_YMIN, c_YMAX);
    end else if (frame_start) begin
      if (w_up)      w_ny = step_dec(r_pos_y, c_YMIN);
      else if (w_dn) w_ny = step_inc(r_pos_y, c_YMAX);
      if (w_lf)      w_nx = step_dec(r_pos_x, c_XMIN);
      else if (w_rt) w_nx = step_inc(r_pos_x, c_XMAX);
    end
  end

  always_ff @(posedge Pclk) begin
    if (rst) begin
      r_pos_x <= c_RST_X;
      r_pos_y <= c_RST_Y;
    end else begin
      r_pos_x <= w_nx;
      r_pos_y <= w_ny;
    end
  end

  always_ff @(posedge Pclk) begin
    if (rst) begin
      r_at_edge <= 4'b0000;
    end else begin
      r_at_edge <= {({1'b0, r_pos_x} == c_XMAX), ({1'b0, r_pos_x} == c_XMIN),
                    ({1'b0, r_pos_y} == c_YMAX), ({1'b0, r_pos_y} == c_YMIN)};
    end
  end

  logic [10:0]       w_dx, w_dy;
  logic [6:0]        w_col, w_row;
  logic              w_in_x, w_in_y, w_in_spr;
  logic [ADDR_W-1:0] w_addr;

  assign w_in_x   = ({1'b0, xx} >= {1'b0, r_pos_x}) &&
                    ({1'b0, xx} <  {1'b0, r_pos_x} + 11'(c_HIT_W));
  assign w_in_y   = ({1'b0, yy} >= {1'b0, r_pos_y}) &&
                    ({1'b0, yy} <  {1'b0, r_pos_y} + 11'(c_HIT_H));
  assign w_in_spr = aactive && w_in_x && w_in_y;

  // Offsets are only meaningful when w_in_spr is set.
  assign w_dx   = {1'b0, xx} - {1'b0, r_pos_x};
  assign w_dy   = {1'b0, yy} - {1'b0, r_pos_y};
  assign w_col  = 7'(w_dx >> c_SHIFT);
  assign w_row  = 7'(w_dy >> c_SHIFT);
  assign w_addr = ADDR_W'(w_row) * ADDR_W'(SPRITE_W) + ADDR_W'(w_col);

  always_ff @(posedge Pclk) begin
    if (rst)           r_rom_addr <= '0;
    else if (w_in_spr) r_rom_addr <= w_addr;
  end

  generate
    if (ROM_LATENCY == 0) begin : g_pipe_single
      always_ff @(posedge Pclk) begin
        if (rst) r_on_pipe <= '0;
        else     r_on_pipe <= w_in_spr;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge Pclk) begin
        if (rst) r_on_pipe <= '0;
        else     r_on_pipe <= {r_on_pipe[ROM_LATENCY-1:0], w_in_spr};
      end
    end
  endgenerate

  assign rom_addr  = r_rom_addr;
  assign sprite_on = r_on_pipe[ROM_LATENCY];
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign at_edge   = r_at_edge;

endmodule
`default_nettype wire

// File: tb/tb_sprite_mover.sv
`default_nettype none
// tb_sprite_mover: directed + randomized stimulus, expectations queued from an
// arithmetic reference model and checked by an independent monitor.
module tb_sprite_mover;
  localparam int SPRITE_W = 15, SPRITE_H = 15, ADDR_W = 10;
  localparam int START_X = 400, START_Y = 300;
  localparam int BOX_X_MIN = 217, BOX_X_MAX = 402, BOX_Y_MIN = 200, BOX_Y_MAX = 375;
  localparam int STEP = 5, ROM_LATENCY = 1;
`ifdef SPRITE_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic              Pclk = 1'b0;
  logic              rst, aactive, frame_start, load_en;
  logic [9:0]        xx, yy, load_x, load_y;
  logic [2:0]        dir;
  logic [ADDR_W-1:0] rom_addr;
  logic              sprite_on;
  logic [9:0]        pos_x, pos_y;
  logic [3:0]        at_edge;

  sprite_mover #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ADDR_W(ADDR_W),
    .START_X(START_X), .START_Y(START_Y),
    .BOX_X_MIN(BOX_X_MIN), .BOX_X_MAX(BOX_X_MAX),
    .BOX_Y_MIN(BOX_Y_MIN), .BOX_Y_MAX(BOX_Y_MAX),
    .STEP(STEP), .ROM_LATENCY(ROM_LATENCY)
  ) dut (
    .Pclk(Pclk), .rst(rst), .xx(xx), .yy(yy), .aactive(aactive),
    .frame_start(frame_start), .dir(dir), .load_en(load_en),
    .load_x(load_x), .load_y(load_y), .rom_addr(rom_addr),
    .sprite_on(sprite_on), .pos_x(pos_x), .pos_y(pos_y), .at_edge(at_edge)
  );

  always #5 Pclk = ~Pclk;

  int cyc = 0;
  always @(posedge Pclk) cyc <= cyc + 1;

  typedef struct { int due; int addr; } pix_t;
  typedef struct { int due; int kind; int x; int y; int e; } evt_t;
  pix_t pq[$];
  evt_t eq[$];

  int n_tests = 0, n_fail = 0;
  bit mon_en = 1'b0;
  int mx, my;
  bit m_exp_on;
  logic [ADDR_W-1:0] addr_d [0:3];

  // Movement per direction code as unit vectors.
  int DXT [8] = '{0, 0, -1, 1, -1, 1, -1, 1};
  int DYT [8] = '{-1, 1, 0, 0, -1, -1, 1, 1};

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int edge_of(int x, int y);
    return ((x == BOX_X_MAX) ? 8 : 0) + ((x == BOX_X_MIN) ? 4 : 0) +
           ((y == BOX_Y_MAX) ? 2 : 0) + ((y == BOX_Y_MIN) ? 1 : 0);
  endfunction

  // One clock of stimulus; the model predicts what the DUT must show later.
  task automatic drive(input bit r, input bit fs, input int d, input bit le,
                       input int lx, input int ly, input bit act, input int px, input int py);
    rst = r; frame_start = fs; dir = 3'(d); load_en = le;
    load_x = 10'(lx); load_y = 10'(ly); aactive = act; xx = 10'(px); yy = 10'(py);
    if (r) begin
      while (pq.size() > 0 && pq[$].due > cyc) void'(pq.pop_back());
      eq.push_back(evt_t'{cyc + 1, 1, 0, 0, 0});
      mx = clampi(START_X, BOX_X_MIN, BOX_X_MAX);
      my = clampi(START_Y, BOX_Y_MIN, BOX_Y_MAX);
      eq.push_back(evt_t'{cyc + 2, 0, mx, my, edge_of(mx, my)});
    end else begin
      if (act && px >= mx && px < mx + SPRITE_W * SC && py >= my && py < my + SPRITE_H * SC)
        pq.push_back(pix_t'{cyc + 1 + ROM_LATENCY, ((py - my) / SC) * SPRITE_W + (px - mx) / SC});
      if (le) begin
        mx = clampi(lx, BOX_X_MIN, BOX_X_MAX);
        my = clampi(ly, BOX_Y_MIN, BOX_Y_MAX);
      end else if (fs) begin
        mx = clampi(mx + DXT[d] * STEP, BOX_X_MIN, BOX_X_MAX);
        my = clampi(my + DYT[d] * STEP, BOX_Y_MIN, BOX_Y_MAX);
      end
      if (le || fs) eq.push_back(evt_t'{cyc + 2, 0, mx, my, edge_of(mx, my)});
    end
    @(posedge Pclk); #1;
  endtask

  task automatic idle(input int n, input bit act);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 0, 0, 0, act, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
  endtask

  task automatic frame(input int d);
    drive(0, 1, d, 0, 0, 0, 0, 0, 0);
    idle(2, 1'b0);
  endtask

  task automatic load(input int lx, input int ly, input bit fs, input int d);
    drive(0, fs, d, 1, lx, ly, 0, 0, 0);
    idle(2, 1'b0);
  endtask

  task automatic reset_pulse();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 1'b0);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1,
                      input int rst_idx, input bit rnd_act);
    int idx;
    idx = 0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        if (idx == rst_idx) drive(1, 0, 0, 0, 0, 0, 0, x, y);
        else drive(0, 0, 0, 0, 0, 0, rnd_act ? ($urandom_range(0, 7) != 0) : 1'b1, x, y);
        idx++;
      end
    idle(4, 1'b0);
  endtask

  always @(negedge Pclk) begin
    for (int k = 3; k > 0; k--) addr_d[k] = addr_d[k - 1];
    addr_d[0] = rom_addr;
    if (mon_en) begin
      while (pq.size() > 0 && pq[0].due < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL pix_stale cyc=%0d entry due=%0d never presented", cyc, pq[0].due);
        void'(pq.pop_front());
      end
      m_exp_on = (pq.size() > 0 && pq[0].due == cyc);
      n_tests++;
      if (sprite_on !== m_exp_on) begin
        n_fail++;
        $display("FAIL sprite_on cyc=%0d got=%0b exp=%0b", cyc, sprite_on, m_exp_on);
      end
      if (m_exp_on) begin
        if (sprite_on === 1'b1) begin
          n_tests++;
          if (addr_d[ROM_LATENCY] !== ADDR_W'(pq[0].addr)) begin
            n_fail++;
            $display("FAIL rom_addr cyc=%0d got=%0d exp=%0d", cyc, addr_d[ROM_LATENCY], pq[0].addr);
          end
        end
        void'(pq.pop_front());
      end
      while (eq.size() > 0 && eq[0].due <= cyc) begin
        n_tests++;
        if (eq[0].due < cyc) begin
          n_fail++;
          $display("FAIL evt_stale cyc=%0d due=%0d", cyc, eq[0].due);
        end else if (eq[0].kind == 1) begin
          if (rom_addr !== '0 || sprite_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out cyc=%0d rom_addr=%0d sprite_on=%0b exp 0/0", cyc, rom_addr, sprite_on);
          end
        end else if (pos_x !== 10'(eq[0].x) || pos_y !== 10'(eq[0].y) || at_edge !== 4'(eq[0].e)) begin
          n_fail++;
          $display("FAIL position cyc=%0d got=(%0d,%0d,e=%b) exp=(%0d,%0d,e=%b)",
                   cyc, pos_x, pos_y, at_edge, eq[0].x, eq[0].y, 4'(eq[0].e));
        end
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; dir = 3'd0; load_en = 1'b0;
    load_x = '0; load_y = '0; aactive = 1'b0; xx = '0; yy = '0;
    for (int k = 0; k < 4; k++) addr_d[k] = '0;
    repeat (2) @(posedge Pclk);
    #1;
    mon_en = 1'b1;
    reset_pulse();

    repeat (30) frame(0);                    // climb to the top bound and stay
    reset_pulse();
    repeat (6) frame(3);                     // right clamps at 402
    reset_pulse();
    for (int i = 0; i < 3; i++) begin        // diagonal with active video between pulses
      drive(0, 1, 6, 0, 0, 0, 0, 0, 0);
      idle(3, 1'b1);
      idle(2, 1'b0);
    end
    reset_pulse();
    load(1000, 10, 1'b1, 1);                 // load overrides a simultaneous move
    load(217, 200, 1'b0, 0);
    scan(214, 234, 198, 216, -1, 1'b0);      // full window incl. both side neighbours
    load(300, 250, 1'b0, 0);
    scan(297, 317, 249, 252, 30, 1'b0);      // reset lands inside the sprite

    for (int it = 0; it < 80; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 4) frame(int'($urandom_range(0, 7)));
      else if (op <= 6) load(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      else if (op == 7) reset_pulse();
      else begin
        for (int j = 0; j < 24; j++) begin
          int px, py;
          if ($urandom_range(0, 3) == 0) begin
            px = int'($urandom_range(0, 1023)); py = int'($urandom_range(0, 1023));
          end else begin
            px = int'($urandom_range(mx - 3, mx + SPRITE_W * SC + 2));
            py = int'($urandom_range(my - 3, my + SPRITE_H * SC + 2));
          end
          drive(0, 0, 0, 0, 0, 0, $urandom_range(0, 5) != 0, px, py);
        end
        idle(3, 1'b0);
      end
    end
    for (int s = 0; s < 2; s++) begin
      load(int'($urandom_range(200, 420)), int'($urandom_range(190, 390)), 1'b0, 0);
      scan(mx - 2, mx + SPRITE_W * SC + 1, my - 1, my + SPRITE_H * SC, -1, 1'b1);
    end
    idle(6, 1'b0);

    n_tests++;
    if (pq.size() != 0 || eq.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending_pix=%0d pending_evt=%0d exp 0/0", pq.size(), eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised sprite engine for the battle box: holds the sprite position, moves it once per video frame from a 3-bit direction code, and clamps it to a configurable rectangle.
- Generates a raster-computed ROM address for the sprite bitmap and a `sprite_on` flag delay-matched to the ROM read latency.
- Sits between the VGA timing generator / input decoder and the sprite ROM + pixel mux. Instantiable for the heart and any other moving object.

Parameters:
- SPRITE_W, 15, sprite width in pixels (1..64)
- SPRITE_H, 15, sprite height in pixels (1..64)
- ADDR_W, 10, ROM address width; SPRITE_W*SPRITE_H must fit
- START_X, 400, reset X of sprite top-left
- START_Y, 300, reset Y of sprite top-left
- BOX_X_MIN, 217, minimum legal X
- BOX_X_MAX, 402, maximum legal X (top-left coordinate)
- BOX_Y_MIN, 200, minimum legal Y
- BOX_Y_MAX, 375, maximum legal Y (top-left coordinate)
- STEP, 5, pixels moved per axis per frame
- ROM_LATENCY, 1, clock cycles from `rom_addr` to ROM data valid (0..3)

Ports:
- Pclk, in, 1, pixel clock
- rst, in, 1, synchronous active-high reset
- xx, in, 10, current pixel X
- yy, in, 10, current pixel Y
- aactive, in, 1, high during the visible area
- frame_start, in, 1, one-cycle pulse at start of vertical blank
- dir, in, 3, movement code
- load_en, in, 1, teleport request
- load_x, in, 10, teleport X
- load_y, in, 10, teleport Y
- rom_addr, out, ADDR_W, sprite ROM address
- sprite_on, out, 1, current ROM data belongs to visible sprite pixel
- pos_x, out, 10, current sprite X
- pos_y, out, 10, current sprite Y
- at_edge, out, 4, {right, left, down, up}: position equals the box bound

Behaviour:
- Reset (synchronous, `Pclk` edge with `rst`=1):
  - `pos_x`=START_X, `pos_y`=START_Y, each clamped into the box.
  - `rom_addr`=0; `sprite_on`=0; whole `sprite_on` pipeline cleared.
  - `at_edge` recomputed from the reset position on the following cycle.
- Position updates happen only on cycles with `frame_start`=1 or `load_en`=1. Position is constant during active video; there is no per-clock drift.
- Priority: rst > load_en > frame_start move.
- load_en: `pos_x`=clamp(load_x, BOX_X_MIN, BOX_X_MAX), `pos_y`=clamp(load_y, BOX_Y_MIN, BOX_Y_MAX). Takes effect next cycle. A `frame_start` move in the same cycle is discarded.
- dir codes (applied on `frame_start`):
  - 000 up; 001 down; 010 left; 011 right.
  - 100 up-left; 101 up-right; 110 down-left; 111 down-right.
  - Diagonal codes move STEP on both axes.
- Clamping:
  - Decrement: new = (pos - BOX_MIN < STEP) ? BOX_MIN : pos - STEP.
  - Increment: new = (BOX_MAX - pos < STEP) ? BOX_MAX : pos + STEP.
  - Compute in 11 bits; no wrap below 0 or above 1023.
  - At a bound, a move toward it holds the position; the other axis still moves.
- `at_edge` is registered, updated the cycle after any position change: bit0 `pos_y`==BOX_Y_MIN, bit1 `pos_y`==BOX_Y_MAX, bit2 `pos_x`==BOX_X_MIN, bit3 `pos_x`==BOX_X_MAX.
- Address stage (every cycle):
  - in_spr = aactive && xx>=pos_x && xx<pos_x+SPRITE_W && yy>=pos_y && yy<pos_y+SPRITE_H.
  - If in_spr: `rom_addr` <= (yy-pos_y)*SPRITE_W + (xx-pos_x), registered. Otherwise `rom_addr` holds its last value.
- Alignment:
  - in_spr is delayed by 1+ROM_LATENCY registers; `sprite_on` is the last stage.
  - For pixel (xx,yy) presented at cycle t, `sprite_on` and ROM data both correspond to that pixel at cycle t+1+ROM_LATENCY.
- Sprite partially outside active area: only active pixels assert; no address wrap.

Optional Feature:
- Macro SPRITE_SCALE2X_EN.
- When defined: sprite is displayed at 2x size.
  - Hit box is 2*SPRITE_W x 2*SPRITE_H.
  - Address = ((yy-pos_y)>>1)*SPRITE_W + ((xx-pos_x)>>1).
  - Clamp bounds are unchanged (they refer to top-left).
- When undefined: 1x behaviour as above; no extra logic.

Test Plan:
- Reset, then hold dir=000 for 30 frames → `pos_y` goes 300,295,... and stops at 200. `at_edge`=4'b0001 from the frame it reaches 200. `pos_x` stays 400.
- From reset, dir=011 for 1 frame → `pos_x`=402, not 405; `at_edge`[3]=1. Hold dir=011 for 5 frames → `pos_x` stays 402.
- dir=110 held across 3 frame_start pulses with `aactive` toggling between them → position changes only on the pulse cycles: (395,305), (390,310), (385,315).
- load_en with (1000,10) asserted in the same cycle as `frame_start` with dir=001 → position (402,200); the move is ignored.
- Raster scan with pos=(217,200), ROM_LATENCY=1 → `sprite_on` rises at cycle t+2 for pixel (217,200) with `rom_addr`=0. Pixel (231,214) gives `rom_addr`=224. Pixels (216,200) and (232,200) never assert `sprite_on`.
- Assert rst mid-scan while `sprite_on`=1 → `sprite_on`=0 on the next edge. Position returns to (400,300); pipeline empty, with no stale asserts over the next 3 cycles.
